// File: rtl/freq_word_recover.sv
// rtl/freq_word_recover.sv - recovers the NCO tuning word from a phase-accumulator sample stream
//
// Purpose:
//   Watches phase samples from a phase-accumulator NCO and measures the step between
//   consecutive accepted samples, modulo 2^W. After LOCK_CNT consecutive identical
//   non-zero steps it declares lock and publishes the step as the tuning word.
//   While locked, it flags mismatching steps. After UNLOCK_CNT consecutive mismatches
//   it drops lock. It also counts accumulator wrap-arounds.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous clear to IDLE with all state zeroed (wins over in_valid)
//   in_valid    phase_in carries a sample this cycle
//   phase_in    phase accumulator sample [W-1:0]
//   step_out    recovered tuning word, meaningful while locked=1 [W-1:0]
//   locked      tuning word is stable
//   wrap_pulse  one-cycle pulse: accepted sample was below the previous one
//   wrap_count  saturating wrap count since reset/clear [15:0]
//   err_pulse   one-cycle pulse: step mismatch while locked
module freq_word_recover #(
  parameter int W          = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] phase_in,
  output logic [W-1:0] step_out,
  output logic         locked,
  output logic         wrap_pulse,
  output logic [15:0]  wrap_count,
  output logic         err_pulse
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   prev_q, prev_d;
  logic [W-1:0]   cand_q, cand_d;
  logic [W-1:0]   step_q, step_d;
  logic [MW-1:0]  match_q, match_d;
  logic [SW-1:0]  miss_q, miss_d;
  logic           locked_q, locked_d;
  logic           wrap_pulse_q, wrap_pulse_d;
  logic           err_pulse_q, err_pulse_d;
  logic [15:0]    wrap_cnt_q, wrap_cnt_d;

  logic [W-1:0]   diff;
  logic           wrap;

  // Subtraction wraps naturally at W bits, which gives the step modulo 2^W.
  assign diff = phase_in - prev_q;
  assign wrap = (phase_in < prev_q);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    cand_d       = cand_q;
    step_d       = step_q;
    match_d      = match_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    wrap_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;

    if (clear) begin
      state_d    = S_IDLE;
      prev_d     = '0;
      cand_d     = '0;
      step_d     = '0;
      match_d    = '0;
      miss_d     = '0;
      locked_d   = 1'b0;
      wrap_cnt_d = '0;
    end else if (in_valid) begin
      prev_d = phase_in;

      // The first sample only primes prev. It has no predecessor, so it yields no step and no wrap.
      if (state_q != S_IDLE && wrap) begin
        wrap_pulse_d = 1'b1;
        if (wrap_cnt_q != 16'hFFFF) begin
          wrap_cnt_d = wrap_cnt_q + 16'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
        end

        S_ACQUIRE: begin
          if (diff == '0) begin
            // A stationary phase (DC) is not a frequency, so it must never lock.
            match_d = '0;
          end else if (diff == cand_q && match_q != '0) begin
            match_d = match_q + 1'b1;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d  = S_LOCKED;
              step_d   = cand_q;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            cand_d  = diff;
            match_d = MW'(1);
          end
        end

        S_LOCKED: begin
          if (diff == step_q) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            miss_d      = miss_q + 1'b1;
            if (miss_q == SW'(UNLOCK_CNT - 1)) begin
              // The new step seeds re-acquisition. step_out keeps the last good word.
              state_d  = S_ACQUIRE;
              locked_d = 1'b0;
              cand_d   = diff;
              match_d  = MW'(diff != '0);
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      cand_q       <= '0;
      step_q       <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      cand_q       <= cand_d;
      step_q       <= step_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_pulse_q  <= err_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign step_out   = step_q;
  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_cnt_q;
  assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_freq_word_recover.sv
// tb/tb_freq_word_recover.sv - directed self-checking bench for freq_word_recover
module tb_freq_word_recover;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  phase_in;
  logic [7:0]  step_out;
  logic        locked;
  logic        wrap_pulse;
  logic [15:0] wrap_count;
  logic        err_pulse;

  int total_cnt;
  int pass_cnt;

  freq_word_recover #(.W(8), .LOCK_CNT(4), .UNLOCK_CNT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .phase_in   (phase_in),
    .step_out   (step_out),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge. Outputs are read at that same point.
  // So after send() returns, the outputs show the response to the sample just accepted.
  task automatic send(input logic v, input logic [7:0] p);
    in_valid = v;
    phase_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    send(1'b1, 8'd33);
    send(1'b1, 8'd66);
    total_cnt++; if (step_out !== 8'd0) $display("FAIL reset_step_out got=%0d exp=0", step_out); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else pass_cnt++;
    total_cnt++; if (wrap_pulse !== 1'b0) $display("FAIL reset_wrap_pulse got=%b exp=0", wrap_pulse); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'd0) $display("FAIL reset_wrap_count got=%0d exp=0", wrap_count); else pass_cnt++;
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); else pass_cnt++;
    rst_n = 1'b1;
    send(1'b0, 8'd0);
  endtask

  task automatic test_lock;
    logic err_seen;
    err_seen = 1'b0;
    send(1'b1, 8'd0);  err_seen |= err_pulse;
    send(1'b1, 8'd20); err_seen |= err_pulse;
    send(1'b1, 8'd40); err_seen |= err_pulse;
    send(1'b1, 8'd60); err_seen |= err_pulse;
    total_cnt++; if (locked !== 1'b0) $display("FAIL lock_early got=%b exp=0", locked); else pass_cnt++;
    send(1'b1, 8'd80); err_seen |= err_pulse;
    total_cnt++; if (locked !== 1'b1) $display("FAIL lock_locked got=%b exp=1", locked); else pass_cnt++;
    total_cnt++; if (step_out !== 8'd20) $display("FAIL lock_step got=%0d exp=20", step_out); else pass_cnt++;
    total_cnt++; if (err_seen !== 1'b0) $display("FAIL lock_no_err got=%b exp=0", err_seen); else pass_cnt++;
  endtask

  task automatic test_wrap;
    for (int p = 100; p <= 240; p += 20) send(1'b1, 8'(p));
    total_cnt++; if (wrap_count !== 16'd0) $display("FAIL wrap_before got=%0d exp=0", wrap_count); else pass_cnt++;
    send(1'b1, 8'd4);
    total_cnt++; if (wrap_pulse !== 1'b1) $display("FAIL wrap_pulse got=%b exp=1", wrap_pulse); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'd1) $display("FAIL wrap_count got=%0d exp=1", wrap_count); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL wrap_locked got=%b exp=1", locked); else pass_cnt++;
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL wrap_err got=%b exp=0", err_pulse); else pass_cnt++;
    send(1'b1, 8'd24);
    total_cnt++; if (wrap_pulse !== 1'b0) $display("FAIL wrap_pulse_once got=%b exp=0", wrap_pulse); else pass_cnt++;
  endtask

  task automatic test_glitch;
    send(1'b1, 8'd49);
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL glitch_err got=%b exp=1", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL glitch_locked got=%b exp=1", locked); else pass_cnt++;
    send(1'b1, 8'd69);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL glitch_err_clear got=%b exp=0", err_pulse); else pass_cnt++;
    send(1'b1, 8'd89);
    // A second isolated glitch must not unlock, because the good steps reset miss_cnt.
    send(1'b1, 8'd114);
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL glitch2_err got=%b exp=1", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL glitch2_locked got=%b exp=1", locked); else pass_cnt++;
    send(1'b1, 8'd134);
    total_cnt++; if (step_out !== 8'd20) $display("FAIL glitch_step got=%0d exp=20", step_out); else pass_cnt++;
  endtask

  task automatic test_retune;
    send(1'b1, 8'd171);
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL retune_err1 got=%b exp=1", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL retune_locked1 got=%b exp=1", locked); else pass_cnt++;
    send(1'b1, 8'd208);
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL retune_err2 got=%b exp=1", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL retune_unlock got=%b exp=0", locked); else pass_cnt++;
    total_cnt++; if (step_out !== 8'd20) $display("FAIL retune_hold got=%0d exp=20", step_out); else pass_cnt++;
    send(1'b1, 8'd245);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL retune_acq_err got=%b exp=0", err_pulse); else pass_cnt++;
    send(1'b1, 8'd26);
    total_cnt++; if (locked !== 1'b0) $display("FAIL retune_early got=%b exp=0", locked); else pass_cnt++;
    send(1'b1, 8'd63);
    total_cnt++; if (locked !== 1'b1) $display("FAIL retune_relock got=%b exp=1", locked); else pass_cnt++;
    total_cnt++; if (step_out !== 8'd37) $display("FAIL retune_step got=%0d exp=37", step_out); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'd2) $display("FAIL retune_wraps got=%0d exp=2", wrap_count); else pass_cnt++;
  endtask

  task automatic test_gaps_and_dc;
    logic any_lock;
    logic any_wrap;
    send(1'b0, 8'd7);
    send(1'b0, 8'd250);
    send(1'b0, 8'd1);
    total_cnt++; if (locked !== 1'b1) $display("FAIL gap_locked got=%b exp=1", locked); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'd2) $display("FAIL gap_wraps got=%0d exp=2", wrap_count); else pass_cnt++;
    total_cnt++; if (wrap_pulse !== 1'b0) $display("FAIL gap_wrap_pulse got=%b exp=0", wrap_pulse); else pass_cnt++;
    send(1'b1, 8'd100);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL gap_resume_err got=%b exp=0", err_pulse); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL gap_resume_locked got=%b exp=1", locked); else pass_cnt++;

    clear = 1'b1;
    send(1'b0, 8'd0);
    clear = 1'b0;
    any_lock = 1'b0;
    any_wrap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 8'd100);
      any_lock |= locked;
      any_wrap |= wrap_pulse;
    end
    total_cnt++; if (any_lock !== 1'b0) $display("FAIL dc_no_lock got=%b exp=0", any_lock); else pass_cnt++;
    total_cnt++; if (any_wrap !== 1'b0) $display("FAIL dc_no_wrap got=%b exp=0", any_wrap); else pass_cnt++;
  endtask

  task automatic test_clear;
    clear = 1'b1;
    send(1'b0, 8'd0);
    clear = 1'b0;
    for (int p = 0; p <= 240; p += 20) send(1'b1, 8'(p));
    send(1'b1, 8'd4);
    total_cnt++; if (locked !== 1'b1 || wrap_count !== 16'd1) $display("FAIL clear_setup locked=%b wraps=%0d exp=1/1", locked, wrap_count); else pass_cnt++;
    clear = 1'b1;
    send(1'b1, 8'd24);
    clear = 1'b0;
    total_cnt++; if (locked !== 1'b0) $display("FAIL clear_locked got=%b exp=0", locked); else pass_cnt++;
    total_cnt++; if (step_out !== 8'd0) $display("FAIL clear_step got=%0d exp=0", step_out); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'd0) $display("FAIL clear_wraps got=%0d exp=0", wrap_count); else pass_cnt++;
    total_cnt++; if (wrap_pulse !== 1'b0 || err_pulse !== 1'b0) $display("FAIL clear_pulses wrap=%b err=%b exp=0/0", wrap_pulse, err_pulse); else pass_cnt++;
    // A lower sample right after clear only re-primes, so it must not count as a wrap.
    send(1'b1, 8'd3);
    total_cnt++; if (wrap_pulse !== 1'b0) $display("FAIL clear_reprime got=%b exp=0", wrap_pulse); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    for (int p = 0; p <= 240; p += 30) send(1'b1, 8'(p));
    send(1'b1, 8'd14);
    total_cnt++; if (locked !== 1'b1) $display("FAIL arst_setup got=%b exp=1", locked); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (locked !== 1'b0 || step_out !== 8'd0) $display("FAIL arst_immediate locked=%b step=%0d exp=0/0", locked, step_out); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'd0) $display("FAIL arst_wraps got=%0d exp=0", wrap_count); else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_saturate;
    logic [7:0] p;
    logic [7:0] prev_p;
    int         wraps;
    int         mid_checked;
    p = 8'd255;
    send(1'b1, p);
    wraps = 0;
    mid_checked = 0;
    while (wraps < 65537) begin
      prev_p = p;
      p = p - 8'd1;
      send(1'b1, p);
      if (p < prev_p) begin
        wraps++;
        if (wraps == 65534) begin
          mid_checked = 1;
          total_cnt++; if (wrap_count !== 16'd65534) $display("FAIL sat_below got=%0d exp=65534", wrap_count); else pass_cnt++;
        end
      end
    end
    total_cnt++; if (mid_checked != 1) $display("FAIL sat_mid_reached got=%0d exp=1", mid_checked); else pass_cnt++;
    total_cnt++; if (wrap_count !== 16'hFFFF) $display("FAIL sat_count got=%0d exp=65535", wrap_count); else pass_cnt++;
    total_cnt++; if (wrap_pulse !== 1'b1) $display("FAIL sat_pulse got=%b exp=1", wrap_pulse); else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    phase_in  = 8'd0;

    test_reset;
    test_lock;
    test_wrap;
    test_glitch;
    test_retune;
    test_gaps_and_dc;
    test_clear;
    test_async_reset;
    test_saturate;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
